// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Accepts a W-bit value on set, shifts it through a 4*DIGITS-bit BCD scratch
// register with add-3 correction, then publishes the packed digits on bcd
// together with a one-cycle ready pulse. The set/ready handshake matches the
// upstream multiplier so its ready can drive set directly.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for set; bin is captured on the edge that accepts set
// SHIFT | one add-3 correction plus one left shift per clock, W clocks
// DONE  | copy scratch to bcd, pulse ready, return to IDLE
module bin_to_bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  ready,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    bin_sr;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   scratch_adj;
    logic [CW-1:0]   cnt;

    // State register; synchronous active-low reset forces IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the counter reaching its terminal value of 1 means
    // the current edge performs the last of the W shifts.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = set ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == CW'(1)) ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction of every digit >= 5, all from pre-correction values;
    // each digit wraps within its own nibble, no carry between digits.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath: capture, corrected shift with countdown, and result publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            ready   <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (set) begin
                        bin_sr  <= bin;
                        scratch <= '0;
                        cnt     <= CW'(W);
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[SW-2:0], bin_sr[W-1]};
                    bin_sr  <= {bin_sr[W-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                end
                DONE: begin
                    bcd   <= scratch;
                    ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Busy covers SHIFT and DONE, so it is already low while ready is high.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: an 8-bit/3-digit instance and a 16-bit/5-digit
// instance. Expected BCD values come from a decimal reference model, are
// queued when a conversion is started and are popped by a monitor when the
// matching ready pulse appears.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        ready8;
    logic [11:0] bcd8;
    logic        set16;
    logic [15:0] bin16;
    logic        busy16;
    logic        ready16;
    logic [19:0] bcd16;

    int errors    = 0;
    int checks    = 0;
    int rdy_cnt8  = 0;
    int rdy_cnt16 = 0;

    logic [19:0] sb8[$];
    logic [19:0] sb16[$];
    logic [19:0] exp8;
    logic [19:0] exp16;
    logic [19:0] last8;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (set8),
        .bin   (bin8),
        .busy  (busy8),
        .ready (ready8),
        .bcd   (bcd8)
    );

    bin_to_bcd_seq #(.W(16), .DIGITS(5)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .set   (set16),
        .bin   (bin16),
        .busy  (busy16),
        .ready (ready16),
        .bcd   (bcd16)
    );

    // Decimal reference: digit i is (v / 10^i) % 10.
    function automatic logic [19:0] to_bcd(input int v, input int nd);
        logic [19:0] r;
        logic [19:0] d;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            d = 20'(x % 10);
            r = r | (d << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    // Scoreboard monitor for the narrow instance.
    always @(negedge clk) begin
        if (ready8 === 1'b1) begin
            rdy_cnt8++;
            checks++;
            if (sb8.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready8: ready pulsed with no conversion pending, bcd=%h", bcd8);
            end else begin
                exp8 = sb8.pop_front();
                if ({8'h00, bcd8} !== exp8) begin
                    errors++;
                    $display("FAIL bcd8: got %h expected %h", bcd8, exp8[11:0]);
                end
            end
            checks++;
            if (busy8 !== 1'b0) begin
                errors++;
                $display("FAIL busy8_during_ready: got %b expected 0", busy8);
            end
        end
    end

    // Scoreboard monitor for the wide instance.
    always @(negedge clk) begin
        if (ready16 === 1'b1) begin
            rdy_cnt16++;
            checks++;
            if (sb16.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready16: ready pulsed with no conversion pending, bcd=%h", bcd16);
            end else begin
                exp16 = sb16.pop_front();
                if (bcd16 !== exp16) begin
                    errors++;
                    $display("FAIL bcd16: got %h expected %h", bcd16, exp16);
                end
            end
        end
    end

    // Pulse set for one cycle; returns 1ns after the accepting edge E0.
    task automatic start8(input int v);
        @(negedge clk);
        set8 = 1'b1;
        bin8 = 8'(v);
        sb8.push_back(to_bcd(v, 3));
        @(posedge clk);
        #1;
        set8 = 1'b0;
        bin8 = 8'hA5;
    endtask

    task automatic start16(input int v);
        @(negedge clk);
        set16 = 1'b1;
        bin16 = 16'(v);
        sb16.push_back(to_bcd(v, 5));
        @(posedge clk);
        #1;
        set16 = 1'b0;
        bin16 = 16'h5A5A;
    endtask

    // Count rising edges until ready is seen on the following falling edge.
    task automatic wait_ready8(input int max, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready8 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_ready16(input int max, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready16 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set8  = 1'b0;
        bin8  = '0;
        set16 = 1'b0;
        bin16 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready8 !== 1'b0) begin errors++; $display("FAIL reset_ready8: got %b expected 0", ready8); end
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
        checks++;
        if (bcd8 !== 12'h000) begin errors++; $display("FAIL reset_bcd8: got %h expected 000", bcd8); end
        checks++;
        if (ready16 !== 1'b0) begin errors++; $display("FAIL reset_ready16: got %b expected 0", ready16); end
        checks++;
        if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
        checks++;
        if (bcd16 !== 20'h00000) begin errors++; $display("FAIL reset_bcd16: got %h expected 00000", bcd16); end
        @(negedge clk);
        rst_n = 1'b1;
        last8 = '0;
    endtask

    task automatic test_single();
        int  vals[5] = '{0, 255, 225, 100, 9};
        int  n;
        int  cnt0;
        bit  seen;
        foreach (vals[k]) begin
            cnt0 = rdy_cnt8;
            start8(vals[k]);
            checks++;
            if (busy8 !== 1'b1) begin
                errors++;
                $display("FAIL single_busy v=%0d: got %b expected 1", vals[k], busy8);
            end
            @(negedge clk);
            checks++;
            if ({8'h00, bcd8} !== last8) begin
                errors++;
                $display("FAIL single_bcd_hold v=%0d: got %h expected %h", vals[k], bcd8, last8[11:0]);
            end
            wait_ready8(40, n, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL single_timeout v=%0d: no ready within 40 cycles", vals[k]);
            end else begin
                checks++;
                if (n + 1 != 10) begin
                    errors++;
                    $display("FAIL single_latency v=%0d: got %0d expected 10", vals[k], n + 1);
                end
            end
            @(negedge clk);
            checks++;
            if (ready8 !== 1'b0) begin
                errors++;
                $display("FAIL single_pulse_width v=%0d: ready got %b expected 0", vals[k], ready8);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (rdy_cnt8 - cnt0 != 1) begin
                errors++;
                $display("FAIL single_pulse_count v=%0d: got %0d expected 1", vals[k], rdy_cnt8 - cnt0);
            end
            last8 = to_bcd(vals[k], 3);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        @(negedge clk);
        set8 = 1'b1;
        bin8 = 8'd0;
        sb8.push_back(to_bcd(0, 3));
        for (int i = 0; i < 256; i++) begin
            wait_ready8(30, n, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL b2b_timeout i=%0d: no ready within 30 cycles", i);
                break;
            end
            checks++;
            if (n != 10) begin
                errors++;
                $display("FAIL b2b_spacing i=%0d: got %0d expected 10", i, n);
            end
            if (i < 255) begin
                bin8 = 8'(i + 1);
                sb8.push_back(to_bcd(i + 1, 3));
            end
        end
        set8 = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (sb8.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: got %0d pending expected 0", sb8.size());
        end
        sb8.delete();
        last8 = to_bcd(255, 3);
    endtask

    task automatic test_set_while_busy();
        int n;
        int cnt0;
        bit seen;
        cnt0 = rdy_cnt8;
        start8(77);
        repeat (2) @(posedge clk);
        #1;
        set8 = 1'b1;
        bin8 = 8'd200;
        repeat (3) @(posedge clk);
        #1;
        set8 = 1'b0;
        bin8 = 8'd0;
        wait_ready8(30, n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL busy_set_timeout: no ready within 30 cycles");
        end else begin
            checks++;
            if (1 + 2 + 3 + n != 10) begin
                errors++;
                $display("FAIL busy_set_latency: got %0d expected 10", 1 + 2 + 3 + n);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL busy_set_restart: busy got %b expected 0", busy8);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (rdy_cnt8 - cnt0 != 1) begin
            errors++;
            $display("FAIL busy_set_pulses: got %0d expected 1", rdy_cnt8 - cnt0);
        end
        checks++;
        if (bcd8 !== 12'h077) begin
            errors++;
            $display("FAIL busy_set_bcd: got %h expected 077", bcd8);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int cnt0;
        bit seen;
        cnt0 = rdy_cnt8;
        start8(123);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb8.delete();
        checks++;
        if (bcd8 !== 12'h000) begin errors++; $display("FAIL midrst_bcd: got %h expected 000", bcd8); end
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
        checks++;
        if (ready8 !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready8); end
        repeat (20) @(negedge clk);
        checks++;
        if (rdy_cnt8 != cnt0) begin
            errors++;
            $display("FAIL midrst_no_pulse: got %0d pulses expected 0", rdy_cnt8 - cnt0);
        end
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy_late: got %b expected 0", busy8); end
        start8(42);
        wait_ready8(30, n, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midrst_after_timeout: no ready within 30 cycles");
        end
        @(negedge clk);
        checks++;
        if (bcd8 !== 12'h042) begin errors++; $display("FAIL midrst_after_bcd: got %h expected 042", bcd8); end
    endtask

    task automatic test_wide();
        int vals[2] = '{65535, 1000};
        int n;
        bit seen;
        foreach (vals[k]) begin
            start16(vals[k]);
            wait_ready16(60, n, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL wide_timeout v=%0d: no ready within 60 cycles", vals[k]);
            end else begin
                checks++;
                if (n + 1 != 18) begin
                    errors++;
                    $display("FAIL wide_latency v=%0d: got %0d expected 18", vals[k], n + 1);
                end
            end
            @(negedge clk);
            checks++;
            if (ready16 !== 1'b0) begin
                errors++;
                $display("FAIL wide_pulse_width v=%0d: ready got %b expected 0", vals[k], ready16);
            end
        end
        checks++;
        if (bcd16 !== 20'h01000) begin
            errors++;
            $display("FAIL wide_bcd_final: got %h expected 01000", bcd16);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_set_while_busy();
        test_reset_mid();
        test_wide();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
